mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that sequences all CPU memory traffic onto the single memory port of the memory/IO controller. It shares that port between the instruction-fetch requester and the data (MEM-stage) requester, and applies per-region wait states. Addresses in the IO window get IO_WAIT cycles; all other addresses get RAM_WAIT cycles. It sits between the CPU core's fetch/MEM stages and the memory/IO controller, and supplies the stall handshake those stages need.

## Interface
- RAM_WAIT, 1: access cycles for a RAM-region transaction; legal 1..255, 0 treated as 1
- IO_WAIT, 3: access cycles for an IO-region transaction; legal 1..255, 0 treated as 1
- IO_BASE, 32'h7000_0000: IO window start, inclusive
- IO_LIMIT, 32'h8000_0000: IO window end, exclusive
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- iReq  in  1  fetch request; held until iAck
- iAddr  in  32  fetch address
- iRdData  out  32  fetched word, registered
- iAck  out  1  one-cycle completion pulse to fetch
- dReq  in  1  data request; held until dAck
- dWr  in  1  1 = write, 0 = read
- dAddr  in  32  data address
- dWtData  in  32  store data
- dRdData  out  32  loaded word, registered
- dAck  out  1  one-cycle completion pulse to data stage
- memCe  out  1  memory port enable toward controller
- memWr  out  1  memory port write strobe
- memAddr  out  32  memory port address
- wtData  out  32  memory port write data
- rdData  in  32  memory port read data (combinational from controller)
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE. Also keeps an 8-bit wait counter, a grant register (I or D), lastGrant, and latched addr/wr/wdata.
- **IDLE, no request:** stay in IDLE.
- **IDLE, single request:** grant that requester.
- **IDLE, both requesting:** grant the requester that is not lastGrant (round-robin).
- **On grant:**
  - latch the address.
  - latch wr = dWr for D, or 0 for I.
  - latch wdata = dWtData for D, or 0 for I.
  - update lastGrant.
  - load counter with N: IO_WAIT if IO_BASE <= addr < IO_LIMIT, else RAM_WAIT.
  - go to ACCESS.
- **ACCESS:**
  - memCe=1, memWr=latched wr, memAddr=latched addr, wtData=latched wdata.
  - counter decrements each cycle.
  - In the last ACCESS cycle (counter==1) on a read, rdData is captured into iRdData or dRdData according to the grant; go to DONE.
- **DONE:** pulse iAck or dAck for exactly one cycle; memCe=0; go to IDLE.
- Writes leave dRdData unchanged. The fetch requester never causes memWr=1.
- **Outside ACCESS:** memCe=0, memWr=0, memAddr=0, wtData=0.
- **Requests during a transaction:** requests and input changes arriving during ACCESS or DONE are ignored. Inputs are sampled only in IDLE.
- **Dropped request:** if req drops mid-transaction, the access still completes and ack still pulses.

## Timing
- **Reset values:**
  - state=IDLE, lastGrant=I (so data wins the first tie), counter=0.
  - memCe=memWr=0, memAddr=wtData=0.
  - iRdData=dRdData=0, iAck=dAck=0, busy=0.
- **Latency:** req seen in IDLE at cycle 0 → ACCESS cycles 1..N → ack in cycle N+1 → IDLE at cycle N+2. Throughput is one transaction per N+2 cycles.
- **Ack to next request:** the requester sees ack at the edge ending DONE and updates req before IDLE samples. A req still high in IDLE is therefore a new transaction.
- **Window boundaries:** 0x6FFF_FFFC → RAM; 0x7000_0000 → IO; 0x7FFF_FFFC → IO; 0x8000_0000 → RAM.
- **Reset mid-transaction:** all outputs return to reset values asynchronously; no ack is issued and the transaction is abandoned.
- busy is combinational from state.

## Test plan
- Reset mid-ACCESS (dReq read, RAM_WAIT=3, rst at cycle 2) → memCe falls immediately, no dAck, state IDLE, dRdData=0.
- iReq only, iAddr=0x0000_0010, RAM_WAIT=1, rdData=0x1234_5678 → memCe=1 in cycle 1 only, memWr=0, iAck in cycle 2, iRdData=0x1234_5678.
- dReq write, dAddr=0x7000_0004, dWtData=0xA5A5_A5A5, IO_WAIT=3 → memCe=memWr=1 for cycles 1-3 with memAddr=0x7000_0004 and wtData=0xA5A5_A5A5; dAck in cycle 4; dRdData unchanged.
- iReq and dReq both high from reset, held through acks and then immediately re-asserted → grant order D, I, D, I; no cycle with both acks high.
- Boundary reads at 0x6FFF_FFFC and 0x8000_0000 with RAM_WAIT=1, IO_WAIT=4 → 1 ACCESS cycle each; read at 0x7FFF_FFFC → 4 ACCESS cycles.
- dReq dropped in cycle 2 of a 3-cycle access → access runs to completion, dAck pulses in cycle 4, then IDLE with busy=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the core/controller side.
interface mem_arbiter_if;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iRdData;
  logic        iAck;
  logic        dReq;
  logic        dWr;
  logic [31:0] dAddr;
  logic [31:0] dWtData;
  logic [31:0] dRdData;
  logic        dAck;
  logic        memCe;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] wtData;
  logic [31:0] rdData;
  logic        busy;

  modport slave (
    input  iReq, iAddr, dReq, dWr, dAddr, dWtData, rdData,
    output iRdData, iAck, dRdData, dAck, memCe, memWr, memAddr, wtData, busy
  );

  modport master (
    output iReq, iAddr, dReq, dWr, dAddr, dWtData, rdData,
    input  iRdData, iAck, dRdData, dAck, memCe, memWr, memAddr, wtData, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with per-region wait states (IO window vs RAM).
module mem_arbiter #(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 3,
  parameter logic [31:0] IO_BASE  = 32'h7000_0000,
  parameter logic [31:0] IO_LIMIT = 32'h8000_0000
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  // Out-of-range wait counts are clamped so the counter always terminates.
  localparam logic [7:0] RamN = (RAM_WAIT == 0) ? 8'd1 :
                                (RAM_WAIT > 255) ? 8'd255 : 8'(RAM_WAIT);
  localparam logic [7:0] IoN  = (IO_WAIT == 0) ? 8'd1 :
                                (IO_WAIT > 255) ? 8'd255 : 8'(IO_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_d_q, gnt_d_d;    // 1 = data requester holds the port
  logic        last_d_q, last_d_d;  // 1 = data was granted most recently
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic        pick_d;
  logic [31:0] sel_addr;
  logic        in_io;
  logic        access;

  always_comb begin
    // Data wins unless fetch is also asking and data had the last turn.
    pick_d   = bus.dReq & (~bus.iReq | ~last_d_q);
    sel_addr = pick_d ? bus.dAddr : bus.iAddr;
    in_io    = (sel_addr >= IO_BASE) && (sel_addr < IO_LIMIT);

    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;

    case (state_q)
      StIdle: begin
        if (bus.iReq | bus.dReq) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          addr_d   = sel_addr;
          wr_d     = pick_d & bus.dWr;
          wdata_d  = pick_d ? bus.dWtData : 32'h0;
          cnt_d    = in_io ? IoN : RamN;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = StDone;
          if (!wr_q) begin
            if (gnt_d_q) drdata_d = bus.rdData;
            else         irdata_d = bus.rdData;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      irdata_q <= 32'h0;
      drdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign access      = (state_q == StAccess);
  assign bus.memCe   = access;
  assign bus.memWr   = access & wr_q;
  assign bus.memAddr = access ? addr_q : 32'h0;
  assign bus.wtData  = access ? wdata_q : 32'h0;
  assign bus.iAck    = (state_q == StDone) & ~gnt_d_q;
  assign bus.dAck    = (state_q == StDone) & gnt_d_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.iRdData = irdata_q;
  assign bus.dRdData = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model
// (round-robin grant, region wait count, read-data capture).
module tb_mem_arbiter;
  localparam int unsigned RAM_W = 1;
  localparam int unsigned IO_W  = 3;
  localparam logic [31:0] IO_B  = 32'h7000_0000;
  localparam logic [31:0] IO_L  = 32'h8000_0000;
  localparam int          LIMIT = 300;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(
    .RAM_WAIT (RAM_W),
    .IO_WAIT  (IO_W),
    .IO_BASE  (IO_B),
    .IO_LIMIT (IO_L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors;
  int          checks;
  bit          m_last_d;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;

  function automatic int exp_n(input logic [31:0] a);
    int w;
    w = (a >= IO_B && a < IO_L) ? int'(IO_W) : int'(RAM_W);
    if (w == 0) w = 1;
    if (w > 255) w = 255;
    return w;
  endfunction

  function automatic bit exp_grant(input bit i, input bit d, input bit last_d);
    if (i && d) return !last_d;
    return d;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return $urandom & 32'hFFFF_FFFC;
      1:       return IO_B + ($urandom & 32'h0FFF_FFFC);
      default: return ($urandom_range(0, 1) != 0) ? IO_B - 32'd4 : IO_L;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.iReq = 1'b0; bus.dReq = 1'b0; bus.dWr = 1'b0;
    bus.iAddr = 32'h0; bus.dAddr = 32'h0; bus.dWtData = 32'h0; bus.rdData = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_last_d = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0;
  endtask

  // Called at an IDLE negedge with requests applied (cycle 0); returns at the ack negedge.
  // rdData gets a fresh random word every ACCESS cycle; rc is the word present at the
  // edge that ends the last ACCESS cycle.
  task automatic observe(input int drop_at, output int fc, output int cc, output int ac,
                         output bit ad, output bit bad, output logic [31:0] a,
                         output logic w, output logic [31:0] wd, output logic [31:0] rc);
    fc = -1; cc = 0; ac = -1; ad = 1'b0; bad = 1'b0;
    a = 32'h0; w = 1'b0; wd = 32'h0; rc = 32'h0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == drop_at) begin bus.iReq = 1'b0; bus.dReq = 1'b0; end
      if (bus.iAck && bus.dAck) bad = 1'b1;
      if (bus.memCe) begin
        if (fc < 0) begin
          fc = k; a = bus.memAddr; w = bus.memWr; wd = bus.wtData;
        end else if (bus.memAddr !== a || bus.memWr !== w || bus.wtData !== wd) begin
          bad = 1'b1;
        end
        cc++;
        bus.rdData = $urandom;
        rc = bus.rdData;
      end else if (bus.memWr !== 1'b0 || bus.memAddr !== 32'h0 || bus.wtData !== 32'h0) begin
        bad = 1'b1;
      end
      if (bus.iAck || bus.dAck) begin
        ac = k; ad = bus.dAck;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.memCe, bus.memWr, bus.iAck, bus.dAck, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.memCe, bus.memWr, bus.iAck, bus.dAck, bus.busy});
    end
    checks++;
    if (bus.memAddr !== 32'h0 || bus.wtData !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h/%h expected 0/0", bus.memAddr, bus.wtData);
    end
    checks++;
    if (bus.iRdData !== 32'h0 || bus.dRdData !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.iRdData, bus.dRdData);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.memCe !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b ce=%b expected 0/0", bus.busy, bus.memCe);
    end
  endtask

  task automatic test_fetch_read();
    int fc, cc, ac, n;
    bit ad, bad;
    logic [31:0] a, wd, rc;
    logic w;
    bus.iReq = 1'b1; bus.iAddr = 32'h0000_0010;
    n = exp_n(bus.iAddr);
    observe(0, fc, cc, ac, ad, bad, a, w, wd, rc);
    bus.iReq = 1'b0;
    m_last_d = 1'b0; m_irdata = rc;
    checks++;
    if (fc !== 1 || cc !== n || ac !== n + 1) begin
      errors++;
      $display("FAIL fetch_timing: got ce@%0d x%0d ack@%0d expected ce@1 x%0d ack@%0d",
               fc, cc, ac, n, n + 1);
    end
    checks++;
    if (ad !== 1'b0 || w !== 1'b0 || a !== 32'h10 || bad) begin
      errors++;
      $display("FAIL fetch_bus: got dack=%b wr=%b addr=%h bad=%b expected 0/0/10/0",
               ad, w, a, bad);
    end
    @(negedge clk);
    checks++;
    if (bus.iRdData !== m_irdata || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rdata: got %h busy=%b expected %h busy=0",
               bus.iRdData, bus.busy, m_irdata);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [4] = '{32'h6FFF_FFFC, 32'h7000_0000, 32'h7FFF_FFFC, 32'h8000_0000};
    int fc, cc, ac, n;
    bit ad, bad;
    logic [31:0] a, wd, rc;
    logic w;
    for (int i = 0; i < 4; i++) begin
      bus.dReq = 1'b1; bus.dWr = 1'b0; bus.dAddr = addrs[i];
      n = exp_n(addrs[i]);
      observe(0, fc, cc, ac, ad, bad, a, w, wd, rc);
      bus.dReq = 1'b0;
      m_last_d = 1'b1; m_drdata = rc;
      checks++;
      if (cc !== n || ac !== n + 1 || ad !== 1'b1 || a !== addrs[i]) begin
        errors++;
        $display("FAIL boundary_%h: got x%0d ack@%0d dack=%b expected x%0d ack@%0d dack=1",
                 addrs[i], cc, ac, ad, n, n + 1);
      end
      @(negedge clk);
      checks++;
      if (bus.dRdData !== m_drdata) begin
        errors++;
        $display("FAIL boundary_rdata: got %h expected %h", bus.dRdData, m_drdata);
      end
    end
  endtask

  task automatic test_io_write();
    int fc, cc, ac, n;
    bit ad, bad;
    logic [31:0] a, wd, rc;
    logic w;
    bus.dReq = 1'b1; bus.dWr = 1'b1; bus.dAddr = 32'h7000_0004; bus.dWtData = 32'hA5A5_A5A5;
    n = exp_n(bus.dAddr);
    observe(0, fc, cc, ac, ad, bad, a, w, wd, rc);
    bus.dReq = 1'b0; bus.dWr = 1'b0;
    m_last_d = 1'b1;
    checks++;
    if (fc !== 1 || cc !== n || ac !== n + 1 || ad !== 1'b1) begin
      errors++;
      $display("FAIL write_timing: got ce@%0d x%0d ack@%0d dack=%b expected 1/%0d/%0d/1",
               fc, cc, ac, ad, n, n + 1);
    end
    checks++;
    if (w !== 1'b1 || a !== 32'h7000_0004 || wd !== 32'hA5A5_A5A5 || bad) begin
      errors++;
      $display("FAIL write_bus: got wr=%b addr=%h data=%h bad=%b expected 1/70000004/a5a5a5a5/0",
               w, a, wd, bad);
    end
    @(negedge clk);
    checks++;
    if (bus.dRdData !== m_drdata) begin
      errors++;
      $display("FAIL write_keeps_rdata: got %h expected %h", bus.dRdData, m_drdata);
    end
  endtask

  task automatic test_drop();
    int fc, cc, ac, n;
    bit ad, bad;
    logic [31:0] a, wd, rc;
    logic w;
    bus.dReq = 1'b1; bus.dWr = 1'b0; bus.dAddr = 32'h7000_0100;
    n = exp_n(bus.dAddr);
    observe(2, fc, cc, ac, ad, bad, a, w, wd, rc);
    m_last_d = 1'b1; m_drdata = rc;
    checks++;
    if (cc !== n || ac !== n + 1 || ad !== 1'b1) begin
      errors++;
      $display("FAIL drop_complete: got x%0d ack@%0d dack=%b expected x%0d ack@%0d dack=1",
               cc, ac, ad, n, n + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.dRdData !== m_drdata) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b rdata=%h expected 0/%h",
               bus.busy, bus.dRdData, m_drdata);
    end
  endtask

  task automatic test_round_robin();
    int fc, cc, ac;
    bit ad, bad, g;
    logic [31:0] a, wd, rc;
    logic w;
    do_reset();
    bus.iAddr = 32'h0000_1000; bus.dAddr = 32'h0000_2000; bus.dWr = 1'b0;
    bus.iReq = 1'b1; bus.dReq = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = exp_grant(bus.iReq, bus.dReq, m_last_d);
      observe(0, fc, cc, ac, ad, bad, a, w, wd, rc);
      checks++;
      if (ad !== g || bad || a !== (g ? bus.dAddr : bus.iAddr)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got dack=%b addr=%h bad=%b expected dack=%b addr=%h",
                 t, ad, a, bad, g, g ? bus.dAddr : bus.iAddr);
      end
      m_last_d = g;
      if (g) m_drdata = rc; else m_irdata = rc;
      bus.iAddr += 32'd4; bus.dAddr += 32'd4;
      @(negedge clk);
    end
    bus.iReq = 1'b0; bus.dReq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.iRdData !== m_irdata || bus.dRdData !== m_drdata) begin
      errors++;
      $display("FAIL rr_rdata: got %h/%h expected %h/%h",
               bus.iRdData, bus.dRdData, m_irdata, m_drdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.dReq = 1'b1; bus.dWr = 1'b0; bus.dAddr = 32'h7000_0020; bus.iReq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.memCe !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_started: got ce=%b expected 1", bus.memCe);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.memCe !== 1'b0 || bus.busy !== 1'b0 || bus.dAck !== 1'b0 || bus.dRdData !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: got ce=%b busy=%b ack=%b rdata=%h expected 0/0/0/0",
               bus.memCe, bus.busy, bus.dAck, bus.dRdData);
    end
    bus.dReq = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.dAck || bus.iAck || bus.memCe) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.dAck || bus.iAck || bus.memCe || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abandoned: got activity=%b expected 0", seen);
    end
    m_last_d = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0;
  endtask

  task automatic test_random();
    int fc, cc, ac, n;
    bit ad, bad, g;
    logic [31:0] a, wd, rc, ea, ewd;
    logic w, ew;
    logic [1:0] r;
    for (int t = 0; t < 40; t++) begin
      if (!bus.iReq && !bus.dReq) begin
        r = 2'($urandom_range(1, 3));
        bus.iReq = r[0]; bus.dReq = r[1];
        bus.iAddr = rand_addr(); bus.dAddr = rand_addr();
        bus.dWr = 1'($urandom_range(0, 1)); bus.dWtData = $urandom;
      end
      g   = exp_grant(bus.iReq, bus.dReq, m_last_d);
      ea  = g ? bus.dAddr : bus.iAddr;
      ew  = g & bus.dWr;
      ewd = g ? bus.dWtData : 32'h0;
      n   = exp_n(ea);
      observe(0, fc, cc, ac, ad, bad, a, w, wd, rc);
      checks++;
      if (ad !== g || fc !== 1 || cc !== n || ac !== n + 1 || bad) begin
        errors++;
        $display("FAIL rand_%0d_timing: got dack=%b ce@%0d x%0d ack@%0d bad=%b expected %b/1/%0d/%0d/0",
                 t, ad, fc, cc, ac, bad, g, n, n + 1);
      end
      checks++;
      if (a !== ea || w !== ew || wd !== ewd) begin
        errors++;
        $display("FAIL rand_%0d_bus: got %h/%b/%h expected %h/%b/%h", t, a, w, wd, ea, ew, ewd);
      end
      m_last_d = g;
      if (!ew) begin
        if (g) m_drdata = rc; else m_irdata = rc;
      end
      if (g) begin
        bus.dReq = 1'($urandom_range(0, 1)); bus.dAddr = rand_addr();
        bus.dWr = 1'($urandom_range(0, 1)); bus.dWtData = $urandom;
      end else begin
        bus.iReq = 1'($urandom_range(0, 1)); bus.iAddr = rand_addr();
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.iRdData !== m_irdata || bus.dRdData !== m_drdata) begin
        errors++;
        $display("FAIL rand_%0d_after: got busy=%b %h/%h expected 0 %h/%h",
                 t, bus.busy, bus.iRdData, bus.dRdData, m_irdata, m_drdata);
      end
    end
    bus.iReq = 1'b0; bus.dReq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0;
    m_last_d = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0;
    rst = 1'b1;
    bus.iReq = 1'b0; bus.dReq = 1'b0; bus.dWr = 1'b0;
    bus.iAddr = 32'h0; bus.dAddr = 32'h0; bus.dWtData = 32'h0; bus.rdData = 32'h0;
    test_reset();
    test_fetch_read();
    test_boundary();
    test_io_write();
    test_drop();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
